// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiter.
// Holds the FSM state encoding and the one-hot to binary conversion used for sel.
package axi_arb_pkg;

  localparam int ARB_MAX_W = 32;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Index of the set bit of a one-hot vector; all-zero input yields 0.
  function automatic logic [4:0] onehot_to_bin(input logic [ARB_MAX_W-1:0] one_hot);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < ARB_MAX_W; i++) begin
      idx = idx | ({5{one_hot[i]}} & 5'(i));
    end
    return idx;
  endfunction

endpackage

// File: rtl/priority_encoder_one_hot.sv
// Isolates the highest set bit of a request vector as a one-hot vector.
// An all-zero input produces an all-zero output.
module priority_encoder_one_hot #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] req_vec,
  output logic [WIDTH-1:0] one_hot
);

  logic found;

  // Scan from the top bit down, keeping only the first set bit seen.
  always_comb begin
    one_hot = {WIDTH{1'b0}};
    found   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      one_hot[i] = req_vec[i] & ~found;
      found      = found | req_vec[i];
    end
  end

endmodule

// File: rtl/axi_packet_arbiter.sv
// Packet-granular arbiter: holds a one-hot grant from request until the granted tlast beat is accepted.
// Fixed priority (highest index wins) by default; define AXI_PACKET_ARBITER_RR_EN for round-robin.
module axi_packet_arbiter
  import axi_arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] req,
  input  logic             o_tvalid,
  input  logic             o_tready,
  input  logic             o_tlast,
  output logic [WIDTH-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  arb_state_t             state;
  arb_state_t             next_state;
  logic [WIDTH-1:0]       pick;
  logic [ARB_MAX_W-1:0]   pick_ext;
  logic [4:0]             pick_idx;
  logic [SEL_W-1:0]       pick_sel;
  logic [WIDTH-1:0]       grant_d;
  logic [SEL_W-1:0]       sel_d;
  logic                   last_beat;

  assign last_beat = o_tvalid & o_tready & o_tlast;

`ifdef AXI_PACKET_ARBITER_RR_EN
  logic [SEL_W-1:0] pointer;
  logic [SEL_W-1:0] pointer_d;
  logic             ptr_valid;
  logic [WIDTH-1:0] below_mask;
  logic [WIDTH-1:0] masked_req;
  logic [WIDTH-1:0] masked_pick;
  logic [WIDTH-1:0] full_pick;

  // Requests strictly below the last granted index.
  always_comb begin
    below_mask = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      below_mask[i] = (SEL_W'(i) < pointer);
    end
  end

  assign masked_req = req & below_mask;

  priority_encoder_one_hot #(.WIDTH(WIDTH)) u_pe_masked (
    .req_vec (masked_req),
    .one_hot (masked_pick)
  );

  priority_encoder_one_hot #(.WIDTH(WIDTH)) u_pe_full (
    .req_vec (req),
    .one_hot (full_pick)
  );

  // Until the first grant after reset the pointer is only nominal, so the top requester starts the rotation.
  assign pick      = (ptr_valid && (|masked_req)) ? masked_pick : full_pick;
  assign pointer_d = ((state == ARB_IDLE) && (|req)) ? pick_sel : pointer;

  // Round-robin pointer: index of the last granted source.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pointer   <= SEL_W'(WIDTH - 1);
      ptr_valid <= 1'b0;
    end else begin
      pointer   <= pointer_d;
      ptr_valid <= ptr_valid | ((state == ARB_IDLE) && (|req));
    end
  end
`else
  priority_encoder_one_hot #(.WIDTH(WIDTH)) u_pe (
    .req_vec (req),
    .one_hot (pick)
  );
`endif

  // Binary index of the selected requester, sized down to SEL_W.
  always_comb begin
    pick_ext              = {ARB_MAX_W{1'b0}};
    pick_ext[WIDTH-1:0]   = pick;
    pick_idx              = onehot_to_bin(pick_ext);
    pick_sel              = SEL_W'(pick_idx);
  end

  // Next state and next registered outputs.
  always_comb begin
    next_state = state;
    grant_d    = grant;
    sel_d      = sel;
    case (state)
      ARB_IDLE: begin
        if (|req) begin
          next_state = ARB_GRANT;
          grant_d    = pick;
          sel_d      = pick_sel;
        end else begin
          grant_d    = {WIDTH{1'b0}};
          sel_d      = {SEL_W{1'b0}};
        end
      end
      ARB_GRANT: begin
        if (last_beat) begin
          next_state = ARB_IDLE;
          grant_d    = {WIDTH{1'b0}};
          sel_d      = {SEL_W{1'b0}};
        end else begin
          grant_d    = grant;
          sel_d      = sel;
        end
      end
      default: begin
        next_state = ARB_IDLE;
        grant_d    = {WIDTH{1'b0}};
        sel_d      = {SEL_W{1'b0}};
      end
    endcase
  end

  // State and output registers; reset and clear have identical effect.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state <= ARB_IDLE;
      grant <= {WIDTH{1'b0}};
      sel   <= {SEL_W{1'b0}};
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      grant <= grant_d;
      sel   <= sel_d;
      busy  <= |grant_d;
    end
  end

endmodule

// File: tb/tb_axi_packet_arbiter.sv
// Self-checking bench for axi_packet_arbiter (WIDTH=4): directed vector table plus multi-cycle sequences.
module tb_axi_packet_arbiter;

  logic       clk;
  logic       reset;
  logic       clear;
  logic [3:0] req;
  logic       o_tvalid;
  logic       o_tready;
  logic       o_tlast;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;

  int total;
  int bad;

  typedef struct {
    logic       rst;
    logic       clr;
    logic [3:0] rq;
    logic       v;
    logic       r;
    logic       l;
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
  } vec_t;

  axi_packet_arbiter #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .req      (req),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .o_tlast  (o_tlast),
    .grant    (grant),
    .sel      (sel),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic clr, input logic [3:0] rq,
                      input logic v, input logic r, input logic l);
    reset    = rst;
    clear    = clr;
    req      = rq;
    o_tvalid = v;
    o_tready = r;
    o_tlast  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es, input logic eb);
    total++;
    if (grant !== eg || sel !== es || busy !== eb) begin
      bad++;
      $display("FAIL %s: grant=%b sel=%0d busy=%b, want grant=%b sel=%0d busy=%b",
               name, grant, sel, busy, eg, es, eb);
    end
  endtask

`ifdef AXI_PACKET_ARBITER_RR_EN
  logic [3:0] rr_exp [5];
  logic [1:0] rr_sel [5];
`else
  vec_t tbl [24];
`endif

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1; clear = 1'b0; req = 4'b0000;
    o_tvalid = 1'b0; o_tready = 1'b0; o_tlast = 1'b0;

`ifndef AXI_PACKET_ARBITER_RR_EN
    //           rst   clr   req      v     r     l      grant    sel   busy
    tbl[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 4'b0101, 1'b1, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 4'b0101, 1'b1, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 4'b0101, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 4'b0101, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1};
    tbl[21] = '{1'b0, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[22] = '{1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1};

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].rst, tbl[i].clr, tbl[i].rq, tbl[i].v, tbl[i].r, tbl[i].l);
      check($sformatf("vec%0d", i), tbl[i].g, tbl[i].s, tbl[i].b);
    end
`endif

    // Handshake gating: tlast with tvalid but no tready must not release.
    step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("gate_reset", 4'b0000, 2'd0, 1'b0);
    step(1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
    check("gate_grant", 4'b0001, 2'd0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1);
      check($sformatf("gate_hold%0d", k), 4'b0001, 2'd0, 1'b1);
    end
    step(1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1);
    check("gate_release", 4'b0000, 2'd0, 1'b0);
    step(1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
    check("gate_regrant", 4'b0001, 2'd0, 1'b1);

`ifdef AXI_PACKET_ARBITER_RR_EN
    rr_exp[0] = 4'b1000; rr_sel[0] = 2'd3;
    rr_exp[1] = 4'b0100; rr_sel[1] = 2'd2;
    rr_exp[2] = 4'b0010; rr_sel[2] = 2'd1;
    rr_exp[3] = 4'b0001; rr_sel[3] = 2'd0;
    rr_exp[4] = 4'b1000; rr_sel[4] = 2'd3;

    // Rotation with all sources requesting and single-beat packets.
    step(1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
    check("rr_reset", 4'b0000, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
      check($sformatf("rr_grant%0d", k), rr_exp[k], rr_sel[k], 1'b1);
      step(1'b0, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b1);
      check($sformatf("rr_idle%0d", k), 4'b0000, 2'd0, 1'b0);
    end

    // Reset during beat 2 of a packet restores the starting pointer.
    step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
    check("rr_pkt", 4'b0100, 2'd2, 1'b1);
    step(1'b0, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0);
    check("rr_beat1", 4'b0100, 2'd2, 1'b1);
    step(1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0);
    check("rr_mid_reset", 4'b0000, 2'd0, 1'b0);
    step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
    check("rr_after_reset", 4'b1000, 2'd3, 1'b1);

    // Clear coinciding with tlast handshake.
    step(1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
    check("rr_clear_tlast", 4'b0000, 2'd0, 1'b0);
    step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
    check("rr_after_clear", 4'b1000, 2'd3, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_packet_arbiter.md
# axi_packet_arbiter

Packet-granular arbiter for WIDTH AXI-Stream sources competing for one output port. It latches a one-hot grant from the request vector and holds it until the granted packet's last beat is accepted downstream. It drives the select of the downstream stream mux. Fixed priority is the default: the highest-index requester wins. Round-robin fairness is a compile-time option.

## Interface
- WIDTH, 4: number of requesting sources; legal range 2..32.
- SEL_W, $clog2(WIDTH): width of the binary select output (derived; do not override).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high; clears all state.
- clear  in  1  synchronous soft reset, same effect as reset; reset takes precedence.
- req  in  WIDTH  per-source tvalid; bit i = source i has a beat pending.
- o_tvalid  in  1  tvalid of the muxed output stream.
- o_tready  in  1  tready of the muxed output stream.
- o_tlast  in  1  tlast of the muxed output stream.
- grant  out  WIDTH  registered one-hot grant; all zero when idle.
- sel  out  SEL_W  binary index of the set grant bit; 0 when idle.
- busy  out  1  high while a grant is held.

## Operation
- Two-state FSM, IDLE and GRANT.
- **IDLE:**
  - If req is nonzero, register grant = one-hot of the selected requester and go to GRANT.
  - Otherwise stay in IDLE with grant = 0.
- **Selection (fixed priority):** isolate the highest set bit of req.
- **GRANT:**
  - grant, sel and busy hold constant.
  - req changes are ignored, including deassertion of the granted bit; the packet must complete.
  - On o_tvalid & o_tready & o_tlast, go to IDLE; grant, sel and busy clear on the next edge.
- **Handshake gating:** o_tvalid or o_tready alone never changes state. A beat counts only when both are high.
- **Outputs:** sel is registered together with grant and encodes the same bit.
- **busy:** equals |grant.
- **No re-grant without IDLE:** the arbiter never moves from one grant directly to another. At least one IDLE cycle separates packets.
- **Reset/clear:**
  - State = IDLE, grant = 0, sel = 0, busy = 0.
  - Round-robin pointer = WIDTH-1 (see Configuration).
  - A reset or clear mid-packet drops the grant on the next edge. Discarding the partial packet is the downstream's responsibility.
- **Simultaneous clear and tlast handshake:** clear wins; the result is identical either way.

## Timing
- **Request to grant:** 1 cycle. req sampled at edge t in IDLE gives grant valid after edge t, i.e. during cycle t+1.
- **Release:** the tlast handshake in cycle n deasserts grant in cycle n+1. The earliest next grant is cycle n+2, giving one bubble per packet.
- **Single-beat packet:** a tlast handshake in the first GRANT cycle is legal and is released as above.
- **Output reset values:** grant = 0, sel = 0, busy = 0.
- **Registered outputs:** all outputs come from flops; there is no combinational path from req or handshake inputs to outputs.

## Configuration
- **Macro:** AXI_PACKET_ARBITER_RR_EN.
- **Defined (round-robin):**
  - A pointer register holds the index of the last granted source; it updates on every IDLE-to-GRANT transition.
  - Selection uses req masked to bits strictly below the pointer, choosing the highest set bit.
  - If the masked vector is zero, selection falls back to the highest set bit of unmasked req.
  - Resulting order with all sources requesting: WIDTH-1, WIDTH-2, ..., 0, WIDTH-1, ...
- **Undefined (fixed priority):**
  - No pointer register.
  - The highest-index requester always wins, so lower sources can starve.

## Structure
- **Shared package axi_arb_pkg:**
  - State enum (ARB_IDLE, ARB_GRANT).
  - One-hot-to-binary function, used for sel.
- **Sub-module:** instantiate the existing priority_encoder_one_hot (WIDTH) for highest-bit isolation.
  - With AXI_PACKET_ARBITER_RR_EN, instantiate it twice: once for the masked request vector, once for the unmasked one.
- No other sub-modules; the FSM, pointer and output registers live in the top module.

## Test plan
- **Fixed priority:** with WIDTH=4 and macro off, hold req=4'b0101 → grant=4'b0100 and sel=2 one cycle later. Complete a 3-beat packet → IDLE for one cycle, then grant=4'b0100 again.
- **Grant hold:** while granted to source 1, raise req[3] and drop req[1] → grant stays 4'b0010 until the tlast handshake. Then grant=0 for one cycle, then grant=4'b1000.
- **Handshake gating:** hold o_tlast=1 and o_tvalid=1 with o_tready=0 for 5 cycles → grant held. Assert o_tready for 1 cycle → grant=0 on the next cycle.
- **Round-robin:** with the macro on and req=4'b1111 held, send single-beat packets → grant sequence 1000, 0100, 0010, 0001, 1000, with one idle cycle between each.
- **Reset mid-packet:** assert reset during beat 2 of a 4-beat packet → grant=0, sel=0, busy=0 on the next cycle. The round-robin pointer is back to 3, so req=4'b1111 next gets 4'b1000.
- **Clear with tlast:** assert clear in the same cycle as a tlast handshake → IDLE next cycle, identical to the reset response; no spurious grant.
